dma_periph_port: RTL and testbench
==================================

Name: dma_periph_port

Overview:
Peripheral-side endpoint of the DRQ/DACK DMA handshake: one channel of a device that requests DMA service and answers the controller's I/O strobes. It buffers bytes in an internal FIFO between a local streaming interface and the DMA I/O bus. Mode dir=0 moves device data to memory (I/O read cycles); dir=1 moves memory data to the device (I/O write cycles). It sits next to a peripheral (UART, sound, video) on the Z80 system bus, wired to one drq/dack pair of the DMA controller.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, at least 2; AW = $clog2(DEPTH).
WAIT_STATES, 0, number of cen cycles ready is held low after a command is first seen; range 0-7.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cen  in  1  clock enable; all state advances only when cen=1
dir  in  1  0 = device->memory (iord), 1 = memory->device (iowr); quasi-static
flush  in  1  clears FIFO, flags and FSM on the next cen cycle
drq  out  1  DMA request to controller
dack  in  1  DMA acknowledge, active-high
iord  in  1  I/O read strobe, active-high
iowr  in  1  I/O write strobe, active-high
tc  in  1  terminal count from controller
din  in  8  data from bus (iowr cycles)
dout  out  8  data to bus (iord cycles)
ready  out  1  wait-state request to controller, 0 = insert wait
loc_wr_valid  in  1  local push request (dir=0)
loc_wr_data  in  8  local push data
loc_wr_ready  out  1  FIFO can accept a byte (dir=0 and not full)
loc_rd_valid  out  1  FIFO has a byte for the device (dir=1 and not empty)
loc_rd_data  out  8  FIFO head (show-ahead)
loc_rd_ready  in  1  local pop request
done  out  1  sticky; set by a committed transfer with tc=1
underrun  out  1  sticky; an iord transfer was committed while the FIFO was empty
overrun  out  1  sticky; an iowr transfer was committed while the FIFO was full
count  out  AW+1  FIFO occupancy

Behaviour:
- Reset (rst_n=0 at posedge clk, independent of cen): FIFO empty, count=0, drq=0, ready=1, dout=8'hFF, done=0, underrun=0, overrun=0, FSM in S_IDLE.
- Sequential updates happen only on cen=1. dout and loc_rd_data show the FIFO head combinationally; when empty they show 8'hFF.
- drq is registered and recomputed every cen cycle:
  - dir=0: drq = !done & (count>=1).
  - dir=1: drq = !done & (count<DEPTH).
  - drq is forced to 0 in the cycle after a commit, so the controller re-samples a fresh value.
- FSM states:
  - S_IDLE: when dack & (iord|iowr), go to S_WAIT if WAIT_STATES>0 (load wcnt=WAIT_STATES, ready=0), else go to S_ACT.
  - S_WAIT: ready=0; decrement wcnt; at wcnt=1 go to S_ACT with ready=1. Strobe deassertion in this state is ignored: no commit, return to S_IDLE.
  - S_ACT: ready=1. While iowr, latch din into wbuf every cen cycle. tc is ORed into tc_seen while a strobe is active. When the strobe (or dack) deasserts, commit and return to S_IDLE.
- Commit:
  - iord cycle: pop the FIFO; if empty, set underrun and do not pop.
  - iowr cycle: push wbuf; if full, set overrun and drop the byte.
  - If tc_seen, set done.
  - The strobe type is latched on entry to S_WAIT/S_ACT; a strobe that does not match dir is still committed according to the latched type.
- Local side:
  - Push when dir=0 & loc_wr_valid & !full.
  - Pop when dir=1 & loc_rd_ready & !empty.
  - A DMA commit and a local access in the same cen cycle are both performed; count is net-adjusted (push + pop leaves count unchanged).
- A change of dir, or flush=1, empties the FIFO, clears done/underrun/overrun and returns the FSM to S_IDLE on that cen cycle; ready goes to 1.
- Pointers wrap modulo DEPTH; count saturates at both bounds via the full/empty guards.

Decomposition:
- Package dma_periph_pkg holds:
  - the FSM enum (S_IDLE, S_WAIT, S_ACT) in one-hot encoding, matching the DMA controller's state style;
  - localparam IDLE_BUS = 8'hFF;
  - a struct for the latched cycle info (is_read, tc_seen).
- Sub-module dma_byte_fifo: synchronous, show-ahead, with cen, flush, push/pop, full/empty/count; instantiated once.

Test Plan:
- dir=0, WAIT_STATES=0: push 3'h? bytes 8'hA1, 8'hB2, 8'hC3 locally -> drq=1. Run 3 dack+iord pulses -> dout shows A1, B2, C3 in turn; after the third commit count=0 and drq=0.
- dir=1, DEPTH=16: run 16 dack+iowr pulses with din=8'h00..8'h0F -> drq drops after the 16th. A 17th pulse with din=8'h55 -> overrun=1, count=16. Local pops return 8'h00 first.
- WAIT_STATES=3: dack+iord held -> ready=0 for exactly 3 cen cycles, then ready=1. Commit occurs only on strobe deassertion.
- tc=1 during the 2nd of 4 queued reads -> done=1 after that commit, drq=0 thereafter with count=2. Asserting flush -> done=0, count=0.
- Same cen cycle: local push (dir=0) and iord commit with count=5 -> count stays 5; data order preserved.
- Assert rst_n=0 mid-S_WAIT with cen=0 -> next posedge gives ready=1, drq=0, count=0, no commit.

Source files
------------

// File: rtl/dma_periph_pkg.sv
// Shared types and constants for the DRQ/DACK peripheral DMA endpoint.
package dma_periph_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned WCNT_W = 3;

  // Value presented on the data outputs when no byte is available
  localparam logic [DATA_W-1:0] IDLE_BUS = 8'hFF;

  // Bus-cycle FSM, one-hot like the controller side
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_WAIT = 3'b010,
    S_ACT  = 3'b100
  } state_t;

  // Information captured about the I/O cycle in progress
  typedef struct packed {
    logic is_read;
    logic tc_seen;
  } cyc_info_t;

endpackage

// File: rtl/dma_byte_fifo.sv
// Show-ahead byte FIFO with clock enable and synchronous flush.
module dma_byte_fifo
  import dma_periph_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = cnt;
  assign rdata   = empty ? IDLE_BUS : mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (cen) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
    end
  end

  // Storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (cen && do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dma_periph_port.sv
// Peripheral endpoint of the DRQ/DACK handshake: FIFO between local stream and DMA I/O bus.
module dma_periph_port
  import dma_periph_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              dir,
  input  logic              flush,
  output logic              drq,
  input  logic              dack,
  input  logic              iord,
  input  logic              iowr,
  input  logic              tc,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              ready,
  input  logic              loc_wr_valid,
  input  logic [DATA_W-1:0] loc_wr_data,
  output logic              loc_wr_ready,
  output logic              loc_rd_valid,
  output logic [DATA_W-1:0] loc_rd_data,
  input  logic              loc_rd_ready,
  output logic              done,
  output logic              underrun,
  output logic              overrun,
  output logic [AW:0]       count
);

  state_t            state;
  cyc_info_t         info;
  logic [WCNT_W-1:0] wcnt;
  logic [DATA_W-1:0] wbuf;
  logic              dir_q;

  logic              full;
  logic              empty;
  logic [AW:0]       fifo_count;
  logic [DATA_W-1:0] head;

  logic              cmd_c;
  logic              clear_c;
  logic              commit_c;
  logic              dma_push_c;
  logic              dma_pop_c;
  logic              loc_push_c;
  logic              loc_pop_c;
  logic              fifo_push_c;
  logic              fifo_pop_c;
  logic [DATA_W-1:0] fifo_wdata_c;

  assign cmd_c    = dack & (iord | iowr);
  assign clear_c  = flush | (dir != dir_q);
  assign commit_c = (state == S_ACT) & ~cmd_c & ~clear_c;

  assign dma_pop_c  = commit_c & info.is_read;
  assign dma_push_c = commit_c & ~info.is_read;

  // A committed bus cycle of the opposite type owns the FIFO port for that cycle
  assign loc_wr_ready = ~dir & ~full & ~dma_push_c;
  assign loc_rd_valid = dir & ~empty & ~dma_pop_c;
  assign loc_push_c   = loc_wr_valid & loc_wr_ready;
  assign loc_pop_c    = loc_rd_ready & loc_rd_valid;

  assign fifo_push_c  = dma_push_c | loc_push_c;
  assign fifo_pop_c   = dma_pop_c | loc_pop_c;
  assign fifo_wdata_c = dma_push_c ? wbuf : loc_wr_data;

  assign dout        = head;
  assign loc_rd_data = head;
  assign count       = fifo_count;

  dma_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .flush (clear_c),
    .push  (fifo_push_c),
    .wdata (fifo_wdata_c),
    .pop   (fifo_pop_c),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Bus-cycle FSM, request generation and sticky status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      info     <= '0;
      wcnt     <= '0;
      wbuf     <= '0;
      dir_q    <= dir;
      ready    <= 1'b1;
      drq      <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else if (cen) begin
      dir_q <= dir;
      if (clear_c) begin
        state    <= S_IDLE;
        info     <= '0;
        wcnt     <= '0;
        ready    <= 1'b1;
        drq      <= 1'b0;
        done     <= 1'b0;
        underrun <= 1'b0;
        overrun  <= 1'b0;
      end else begin
        if (commit_c && info.tc_seen) done     <= 1'b1;
        if (dma_pop_c && empty)       underrun <= 1'b1;
        if (dma_push_c && full)       overrun  <= 1'b1;

        // Drop the request right after a commit so the controller re-samples
        if (commit_c)  drq <= 1'b0;
        else if (dir)  drq <= ~done & (fifo_count < (AW+1)'(DEPTH));
        else           drq <= ~done & (fifo_count != '0);

        case (state)
          S_IDLE: begin
            ready <= 1'b1;
            if (cmd_c) begin
              info.is_read <= iord;
              info.tc_seen <= tc;
              if (iowr) wbuf <= din;
              if (WAIT_STATES > 0) begin
                state <= S_WAIT;
                wcnt  <= WCNT_W'(WAIT_STATES);
                ready <= 1'b0;
              end else begin
                state <= S_ACT;
              end
            end
          end
          S_WAIT: begin
            if (!cmd_c) begin
              // Strobe abandoned during wait states: no transfer
              state <= S_IDLE;
              ready <= 1'b1;
            end else begin
              info.tc_seen <= info.tc_seen | tc;
              if (iowr) wbuf <= din;
              if (wcnt == WCNT_W'(1)) begin
                state <= S_ACT;
                ready <= 1'b1;
              end else begin
                wcnt  <= wcnt - WCNT_W'(1);
                ready <= 1'b0;
              end
            end
          end
          S_ACT: begin
            ready <= 1'b1;
            if (!cmd_c) begin
              state <= S_IDLE;
            end else begin
              info.tc_seen <= info.tc_seen | tc;
              if (iowr) wbuf <= din;
            end
          end
          default: begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_periph_port.sv
// Scoreboard bench: two endpoints (3 and 0 wait states) driven in lockstep.
module tb_dma_periph_port;
  import dma_periph_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic clk = 1'b0;
  logic rst_n, cen, dir, flush, dack, iord, iowr, tc;
  logic [7:0] din, loc_wr_data;
  logic loc_wr_valid, loc_rd_ready;

  logic drq, ready, loc_wr_ready, loc_rd_valid, done, underrun, overrun;
  logic [7:0] dout, loc_rd_data;
  logic [AW:0] count;

  logic drq_z, ready_z, loc_wr_ready_z, loc_rd_valid_z, done_z, underrun_z, overrun_z;
  logic [7:0] dout_z, loc_rd_data_z;
  logic [AW:0] count_z;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  dma_periph_port #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dir(dir), .flush(flush), .drq(drq),
    .dack(dack), .iord(iord), .iowr(iowr), .tc(tc), .din(din), .dout(dout),
    .ready(ready), .loc_wr_valid(loc_wr_valid), .loc_wr_data(loc_wr_data),
    .loc_wr_ready(loc_wr_ready), .loc_rd_valid(loc_rd_valid), .loc_rd_data(loc_rd_data),
    .loc_rd_ready(loc_rd_ready), .done(done), .underrun(underrun), .overrun(overrun),
    .count(count)
  );

  dma_periph_port #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dir(dir), .flush(flush), .drq(drq_z),
    .dack(dack), .iord(iord), .iowr(iowr), .tc(tc), .din(din), .dout(dout_z),
    .ready(ready_z), .loc_wr_valid(loc_wr_valid), .loc_wr_data(loc_wr_data),
    .loc_wr_ready(loc_wr_ready_z), .loc_rd_valid(loc_rd_valid_z), .loc_rd_data(loc_rd_data_z),
    .loc_rd_ready(loc_rd_ready), .done(done_z), .underrun(underrun_z), .overrun(overrun_z),
    .count(count_z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Occupancy of both instances against the scoreboard depth
  task automatic chk_count(input string tag);
    chk({tag, "_cnt"}, 32'(count), 32'(sb.size()));
    chk({tag, "_cnt0"}, 32'(count_z), 32'(sb.size()));
  endtask

  task automatic loc_push(input logic [7:0] d);
    chk("loc_wr_ready", 32'(loc_wr_ready), 32'd1);
    loc_wr_valid = 1'b1;
    loc_wr_data  = d;
    step();
    loc_wr_valid = 1'b0;
    sb.push_back(d);
  endtask

  task automatic loc_pop();
    logic [7:0] want;
    want = sb.pop_front();
    chk("loc_rd_valid", 32'(loc_rd_valid), 32'd1);
    chk("loc_rd_data", 32'(loc_rd_data), 32'(want));
    chk("loc_rd_data0", 32'(loc_rd_data_z), 32'(want));
    loc_rd_ready = 1'b1;
    step();
    loc_rd_ready = 1'b0;
  endtask

  // One DMA I/O cycle; strobe held until the wait-state instance is ready
  task automatic dma_cycle(input logic rd, input logic [7:0] d, input logic t, input int hold,
                           input logic cpush, input logic [7:0] cdata, output int nwait);
    logic [7:0] want;
    dack = 1'b1; iord = rd; iowr = ~rd; din = d; tc = t;
    step();
    nwait = 0;
    while (ready == 1'b0 && nwait < 20) begin
      nwait++;
      step();
    end
    if (nwait >= 20) chk("ready_timeout", 32'd0, 32'd1);
    chk("ready0_act", 32'(ready_z), 32'd1);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_cnt", 32'(count), 32'(sb.size()));
    end
    if (rd) begin
      want = IDLE_BUS;
      if (sb.size() > 0) want = sb.pop_front();
      chk("dout", 32'(dout), 32'(want));
      chk("dout0", 32'(dout_z), 32'(want));
    end
    dack = 1'b0; iord = 1'b0; iowr = 1'b0; tc = 1'b0;
    if (cpush) begin
      loc_wr_valid = 1'b1;
      loc_wr_data  = cdata;
    end
    step();
    loc_wr_valid = 1'b0;
    if (!rd && sb.size() < DEPTH) sb.push_back(d);
    if (cpush) sb.push_back(cdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int nw;
    rst_n = 1'b0; cen = 1'b1; dir = 1'b0; flush = 1'b0;
    dack = 1'b0; iord = 1'b0; iowr = 1'b0; tc = 1'b0; din = '0;
    loc_wr_valid = 1'b0; loc_wr_data = '0; loc_rd_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_drq", 32'(drq), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_dout", 32'(dout), 32'hFF);
    chk("rst_flags", 32'({done, underrun, overrun}), 32'd0);
    chk_count("rst");

    // Device -> memory: three bytes read back in order
    loc_push(8'hA1); loc_push(8'hB2); loc_push(8'hC3);
    step();
    chk("drq_fill", 32'(drq), 32'd1);
    chk("drq_fill0", 32'(drq_z), 32'd1);
    chk_count("fill3");
    for (int i = 0; i < 3; i++) dma_cycle(1'b1, 8'h00, 1'b0, 0, 1'b0, 8'h00, nw);
    chk_count("drain3");
    step();
    chk("drq_empty", 32'(drq), 32'd0);
    chk("drq_empty0", 32'(drq_z), 32'd0);

    // Wait states: exactly three low cycles, commit only on strobe release
    loc_push(8'h11);
    dma_cycle(1'b1, 8'h00, 1'b0, 2, 1'b0, 8'h00, nw);
    chk("wait_cycles", 32'(nw), 32'd3);
    chk_count("ws_commit");

    // Terminal count on the second of four reads
    loc_push(8'h20); loc_push(8'h21); loc_push(8'h22); loc_push(8'h23);
    dma_cycle(1'b1, 8'h00, 1'b0, 0, 1'b0, 8'h00, nw);
    chk("done_early", 32'(done), 32'd0);
    dma_cycle(1'b1, 8'h00, 1'b1, 0, 1'b0, 8'h00, nw);
    chk("done_tc", 32'(done), 32'd1);
    chk("done_tc0", 32'(done_z), 32'd1);
    chk_count("tc");
    step(); step();
    chk("drq_done", 32'(drq), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    sb.delete();
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_dout", 32'(dout), 32'hFF);
    chk_count("flush");

    // Concurrent local push and DMA read commit
    for (int i = 0; i < 5; i++) loc_push(8'(8'h30 + i));
    dma_cycle(1'b1, 8'h00, 1'b0, 0, 1'b1, 8'h35, nw);
    chk_count("concur");
    for (int i = 0; i < 5; i++) dma_cycle(1'b1, 8'h00, 1'b0, 0, 1'b0, 8'h00, nw);

    // Read from an empty FIFO
    dma_cycle(1'b1, 8'h00, 1'b0, 0, 1'b0, 8'h00, nw);
    chk("underrun", 32'(underrun), 32'd1);
    chk("underrun0", 32'(underrun_z), 32'd1);
    chk_count("underrun");

    // Memory -> device: direction change clears flags, then fill to full
    dir = 1'b1;
    step(); step();
    sb.delete();
    chk("dir_clr", 32'(underrun), 32'd0);
    chk("drq_dir1", 32'(drq), 32'd1);
    for (int i = 0; i < 16; i++) dma_cycle(1'b0, 8'(i), 1'b0, 0, 1'b0, 8'h00, nw);
    step();
    chk("drq_full", 32'(drq), 32'd0);
    chk("drq_full0", 32'(drq_z), 32'd0);
    chk_count("full");
    dma_cycle(1'b0, 8'h55, 1'b0, 0, 1'b0, 8'h00, nw);
    chk("overrun", 32'(overrun), 32'd1);
    chk("overrun0", 32'(overrun_z), 32'd1);
    chk_count("overrun");
    for (int i = 0; i < 3; i++) loc_pop();
    chk_count("pops");

    // Clock enable low freezes the FIFO
    cen = 1'b0;
    loc_rd_ready = 1'b1;
    step(); step();
    loc_rd_ready = 1'b0;
    cen = 1'b1;
    chk_count("cen_off");
    chk("cen_head", 32'(loc_rd_data), 32'(sb[0]));

    // Synchronous reset in the middle of wait states with cen low
    dack = 1'b1; iowr = 1'b1; din = 8'h77;
    step();
    chk("mid_wait_ready", 32'(ready), 32'd0);
    cen = 1'b0; rst_n = 1'b0;
    step();
    sb.delete();
    chk("rstw_ready", 32'(ready), 32'd1);
    chk("rstw_drq", 32'(drq), 32'd0);
    chk("rstw_flags", 32'({done, underrun, overrun}), 32'd0);
    chk_count("rstw");
    rst_n = 1'b1; cen = 1'b1; dack = 1'b0; iowr = 1'b0;
    step(); step();
    chk_count("rstw_nocommit");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
